// File: rtl/adc_oversample_reader_if.sv
// adc_oversample_reader_if
//   Groups the ADC pins, the capture control/status lines and the result
//   stream of the oversampling ADC reader.
//   master : the reader (drives cs_n/sclk, status and the result stream)
//   slave  : the environment (ADC data, capture requests, downstream ready)
// Signals:
//   capture_start, overrun_clear : capture request / sticky-overrun clear
//   sdata, cs_n, sclk            : ADC serial pins
//   capture_done                 : pixel-hold point reached, sequencer may advance
//   out_valid, out_ready, out_data : result handshake
//   busy, overrun                : status
interface adc_oversample_reader_if #(
  parameter int OUT_WIDTH = 8
);
  logic                 capture_start;
  logic                 sdata;
  logic                 out_ready;
  logic                 overrun_clear;
  logic                 cs_n;
  logic                 sclk;
  logic                 capture_done;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 busy;
  logic                 overrun;

  modport master (
    input  capture_start, sdata, out_ready, overrun_clear,
    output cs_n, sclk, capture_done, out_valid, out_data, busy, overrun
  );

  modport slave (
    output capture_start, sdata, out_ready, overrun_clear,
    input  cs_n, sclk, capture_done, out_valid, out_data, busy, overrun
  );
endinterface

// File: rtl/adc_oversample_reader.sv
// adc_oversample_reader
//   Serial-ADC front end for the ADCxx1S101 family. Each conversion is a
//   TRACK phase (cs_n high) followed by a 16-SCLK cs_n-low frame. 2^AVG_LOG2
//   conversions of the same held pixel are summed and averaged, and the
//   MSB-justified OUT_WIDTH result is offered on a valid/ready handshake.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : adc_oversample_reader_if.master (ADC pins, control, result)
module adc_oversample_reader #(
  parameter int ADC_BITS     = 12,
  parameter int OUT_WIDTH    = 8,
  parameter int CLK_DIV      = 2,
  parameter int TRACK_CYCLES = 14,
  parameter int LEAD_ZEROS   = 3,
  parameter int AVG_LOG2     = 0
) (
  input logic                      clk,
  input logic                      reset,
  adc_oversample_reader_if.master  bus
);

  if (ADC_BITS < 8 || ADC_BITS > 12) begin : g_err_bits
    $error("ADC_BITS must be in 8..12");
  end
  if (ADC_BITS + LEAD_ZEROS > 16) begin : g_err_lead
    $error("ADC_BITS + LEAD_ZEROS must not exceed 16");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_err_div
    $error("CLK_DIV must be even and >= 2");
  end
  if (OUT_WIDTH > ADC_BITS) begin : g_err_width
    $error("OUT_WIDTH must not exceed ADC_BITS");
  end
  if (TRACK_CYCLES < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 3) begin : g_err_misc
    $error("TRACK_CYCLES must be >= 1 and AVG_LOG2 in 0..3");
  end

  localparam int FRAME_CYC = 16 * CLK_DIV;
  localparam int CNT_MAX   = (TRACK_CYCLES > FRAME_CYC) ? TRACK_CYCLES : FRAME_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam int ACC_W     = ADC_BITS + AVG_LOG2;
  localparam int K_W       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [CNT_W-1:0] TRK_LAST = CNT_W'(TRACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_C    = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] P_FIRST  = CNT_W'(LEAD_ZEROS);
  localparam logic [CNT_W-1:0] P_END    = CNT_W'(LEAD_ZEROS + ADC_BITS);
  localparam logic [K_W-1:0]   K_LAST   = K_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, TRACK, FRAME, ACCUM, OUTPUT} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;       // cycle index within TRACK / FRAME
  logic [K_W-1:0]       k;                  // conversion index within a capture
  logic [ADC_BITS-1:0]  shreg;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic                 pending, overrun_q;
  logic                 cs_n_q, sclk_q, done_q;
  logic [OUT_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]     period, phase, phase_nxt;
  logic                 sample_en, accept, busy_w, ovr_evt;

  assign period    = cnt / DIV_C;
  assign phase     = cnt % DIV_C;
  assign phase_nxt = cnt_nxt % DIV_C;
  // Sample on the last high cycle of each data-bearing SCLK period.
  assign sample_en = (state == FRAME) && (phase == PH_LAST) &&
                     (period >= P_FIRST) && (period < P_END);
  assign acc_sum   = acc + ACC_W'(shreg);
  assign busy_w    = (state != IDLE);
  assign accept    = (state == OUTPUT) && bus.out_ready;
  // A request arriving while one is already queued is dropped, unless the
  // queued one is consumed by an accept in this very cycle.
  assign ovr_evt   = bus.capture_start && busy_w && pending && !accept;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.capture_start) state_nxt = TRACK;
      end
      TRACK: if (cnt == TRK_LAST) begin
        state_nxt = FRAME;
        cnt_nxt   = '0;
      end
      FRAME: if (cnt == FRM_LAST) begin
        state_nxt = ACCUM;
        cnt_nxt   = '0;
      end
      ACCUM: begin
        cnt_nxt   = '0;
        state_nxt = (k == K_LAST) ? OUTPUT : TRACK;
      end
      OUTPUT: begin
        cnt_nxt = '0;
        if (bus.out_ready)
          state_nxt = (pending || bus.capture_start) ? TRACK : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      shreg     <= '0;
      acc       <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // Pins are registered from next-state so they are glitch-free and
      // line up exactly with the FRAME state cycles.
      cs_n_q <= (state_nxt != FRAME);
      sclk_q <= !((state_nxt == FRAME) && (phase_nxt < HALF_C));
      done_q <= (state_nxt == FRAME) && (state != FRAME) && (k == K_LAST);

      if (sample_en) shreg <= {shreg[ADC_BITS-2:0], bus.sdata};

      if (state == ACCUM) begin
        shreg <= '0;
        if (k == K_LAST) begin
          acc    <= '0;
          k      <= '0;
          // Top OUT_WIDTH bits of (sum >> AVG_LOG2) are simply the top bits of sum.
          data_q <= acc_sum[ACC_W-1 -: OUT_WIDTH];
        end else begin
          acc <= acc_sum;
          k   <= k + 1'b1;
        end
      end

      if (accept)
        pending <= pending && bus.capture_start;
      else if (bus.capture_start && busy_w)
        pending <= 1'b1;

      overrun_q <= ovr_evt || (overrun_q && !bus.overrun_clear);
    end
  end

  assign bus.cs_n         = cs_n_q;
  assign bus.sclk         = sclk_q;
  assign bus.capture_done = done_q;
  assign bus.out_valid    = (state == OUTPUT);
  assign bus.out_data     = data_q;
  assign bus.busy         = busy_w;
  assign bus.overrun      = overrun_q;

endmodule

// File: doc/adc_oversample_reader.md
Name: adc_oversample_reader

Overview:
Parametrised serial-ADC front end for the TI ADCxx1S101 family, the next-generation pixel reader for the stonyman imager path.
- Runs each conversion as a TRACK phase followed by a 16-SCLK CS_n-low frame.
- Optionally averages 2^AVG_LOG2 back-to-back conversions of the same held pixel.
- Returns an MSB-justified OUT_WIDTH result over a valid/ready handshake to the pixel FIFO.
- Signals the stonyman sequencer with capture_done so it can advance to the next pixel.

Parameters:
ADC_BITS, 12, converter resolution; legal range 8..12.
OUT_WIDTH, 8, output word width; must be <= ADC_BITS.
CLK_DIV, 2, clk cycles per SCLK period; even, >= 2.
TRACK_CYCLES, 14, clk cycles CS_n held high before each frame; >= 1.
LEAD_ZEROS, 3, SCLK periods before the MSB appears on sdata.
AVG_LOG2, 0, log2 of conversions averaged per capture; 0..3.

Ports:
clk  in  1  system clock (40 MHz nominal)
reset  in  1  synchronous, active-high
capture_start  in  1  single-cycle capture request
sdata  in  1  ADC serial data
out_ready  in  1  downstream accepts (driven by ~fifo_full)
overrun_clear  in  1  clears overrun
cs_n  out  1  ADC chip select
sclk  out  1  ADC serial clock
capture_done  out  1  one-cycle pulse: pixel may be advanced
out_valid  out  1  out_data is valid
out_data  out  OUT_WIDTH  averaged result
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: a request was dropped

Behaviour:
- Reset values: cs_n=1, sclk=1, capture_done=0, out_valid=0, out_data=0, busy=0, overrun=0. All internal state (accumulator, counters, pending flag) is cleared.
- Reset mid-frame: cs_n rises the cycle after reset is sampled, and any partial result is discarded.
- FSM: IDLE, TRACK, FRAME, ACCUM, OUTPUT.
- IDLE: on capture_start -> TRACK next cycle. Conversion index k=0, accumulator=0.
- TRACK: cs_n=1, sclk=1, lasts exactly TRACK_CYCLES cycles, then -> FRAME.
- FRAME timing: cs_n=0 for exactly 16*CLK_DIV cycles. Each SCLK period is CLK_DIV/2 cycles low followed by CLK_DIV/2 cycles high, starting with a falling edge on the first cs_n-low cycle. This gives 16 falling edges.
- FRAME sampling: sdata is sampled on the last high-phase cycle of SCLK period p (0..15). Periods p = LEAD_ZEROS .. LEAD_ZEROS+ADC_BITS-1 shift in data MSB first. All other periods are ignored.
- capture_done: one-cycle pulse on the first cs_n-low cycle of the final conversion (k = 2^AVG_LOG2 - 1). This is the point where the pixel level is held.
- FRAME end -> ACCUM (1 cycle, cs_n=1): the sample is added to an accumulator of width ADC_BITS+AVG_LOG2, which never overflows.
  - If k < 2^AVG_LOG2 - 1: k++, -> TRACK.
  - Otherwise: avg = acc >> AVG_LOG2 (truncating), out_data = avg[ADC_BITS-1 : ADC_BITS-OUT_WIDTH], -> OUTPUT.
- OUTPUT: out_valid=1 and out_data held stable until the cycle in which out_valid && out_ready. out_valid drops the next cycle. Next state is TRACK if pending is set (pending cleared), else IDLE.
- Pending request:
  - capture_start while busy sets pending.
  - capture_start while pending is already set sets overrun; the request is dropped.
  - capture_start in IDLE starts directly and does not set pending.
- overrun priority: overrun_clear and a new overrun event in the same cycle leave overrun=1.
- Latency with AVG_LOG2=0, no stall: capture_start sampled at cycle 0, TRACK at 1..TRACK_CYCLES, out_valid at cycle TRACK_CYCLES+16*CLK_DIV+2.
- Quiet time between frames is guaranteed by TRACK (cs_n high >= TRACK_CYCLES).
- Elaboration-time errors on illegal parameters: ADC_BITS+LEAD_ZEROS > 16, odd CLK_DIV, OUT_WIDTH > ADC_BITS.

Test Plan:
- Defaults, ADC model returns 0xA5C, single capture_start, out_ready=1 -> cs_n low exactly 32 cycles, 16 sclk falling edges, out_data=0xA5, one out_valid pulse, capture_done once.
- AVG_LOG2=2, samples 0x100, 0x104, 0x108, 0x10D -> four frames each preceded by 14-cycle TRACK; acc=0x419, avg=0x106, out_data=0x10; capture_done only on the 4th frame.
- out_ready=0 for 50 cycles after out_valid, capture_start once during stall -> out_data stable, no new frame during stall; after accept, TRACK begins next cycle with no IDLE; overrun=0.
- Three capture_start pulses during one conversion -> second sets pending, third sets overrun=1; overrun_clear pulse -> overrun=0; exactly two outputs produced.
- reset asserted at cycle 10 of FRAME -> next cycle cs_n=1, sclk=1, busy=0, out_valid=0; a fresh capture yields the correct value with no stale bits.
- ADC_BITS=10, OUT_WIDTH=10, CLK_DIV=4, sample 0x2F3 -> cs_n low 64 cycles, out_data=0x2F3.
